// File: rtl/quad_decoder_bank.sv
// N-channel quadrature decoder: per-pin 2-FF sync, run-length glitch filter, 4x decode,
// sticky illegal-transition / wrap flags, per-channel clear and atomic all-channel snapshot.
module quad_ch #(
  parameter int CNT_W    = 32,
  parameter int FILT_LEN = 4,
  parameter bit INV      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             cnt_clr,
  input  logic             flag_clr,
  input  logic             snap_req,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] snap_count,
  output logic             err,
  output logic             wrap
);
  localparam int FW = $clog2(FILT_LEN + 1);
  localparam logic [FW-1:0] FL = FW'(FILT_LEN);
  localparam logic [CNT_W-1:0] CMAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CMIN = {1'b1, {(CNT_W-1){1'b0}}};

  logic [1:0]    sync1, raw, cand, filt, prev, dlt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic          load, ld_q, primed;
  logic          fwd, rev, bad, up, dn;

  // Gray position of an AB pair along the forward sequence 00,01,11,10
  function automatic logic [1:0] pos(input logic [1:0] ab);
    case (ab)
      2'b00:   pos = 2'd0;
      2'b01:   pos = 2'd1;
      2'b11:   pos = 2'd2;
      default: pos = 2'd3;
    endcase
  endfunction

  always_comb begin
    if (raw != cand)      fcnt_nxt = FW'(1);
    else if (fcnt == FL)  fcnt_nxt = FL;
    else                  fcnt_nxt = fcnt + 1'b1;
    // Load once when the run first reaches FILT_LEN; a saturated run does not reload.
    load = (fcnt_nxt == FL) && !((raw == cand) && (fcnt == FL));
    dlt  = pos(filt) - pos(prev);
    fwd  = primed && (dlt == 2'd1);
    rev  = primed && (dlt == 2'd3);
    bad  = primed && (dlt == 2'd2);
    up   = INV ? rev : fwd;
    dn   = INV ? fwd : rev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      raw        <= '0;
      cand       <= '0;
      fcnt       <= '0;
      filt       <= '0;
      prev       <= '0;
      ld_q       <= 1'b0;
      primed     <= 1'b0;
      count      <= '0;
      snap_count <= '0;
      err        <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      sync1 <= {a, b};
      raw   <= sync1;
      cand  <= raw;
      fcnt  <= fcnt_nxt;
      if (load) filt <= raw;
      // primed lags the first load by one edge so that load is absorbed without a step
      ld_q   <= load;
      primed <= primed | ld_q;
      prev   <= filt;
      if (cnt_clr)   count <= '0;
      else if (up)   count <= count + 1'b1;
      else if (dn)   count <= count - 1'b1;
      err  <= bad | (err & ~flag_clr);
      wrap <= (!cnt_clr && ((up && count == CMAX) || (dn && count == CMIN))) | (wrap & ~flag_clr);
      if (snap_req) snap_count <= count;
    end
  end
endmodule

module quad_decoder_bank #(
  parameter int                NUM_CH   = 12,
  parameter int                CNT_W    = 32,
  parameter int                FILT_LEN = 4,
  parameter logic [NUM_CH-1:0] DIR_INV  = '0
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic [NUM_CH-1:0]       quad_a,
  input  logic [NUM_CH-1:0]       quad_b,
  input  logic [NUM_CH-1:0]       cnt_clr,
  input  logic [NUM_CH-1:0]       flag_clr,
  input  logic                    snap_req,
  output logic [NUM_CH*CNT_W-1:0] count_o,
  output logic [NUM_CH*CNT_W-1:0] snap_count_o,
  output logic                    snap_valid,
  output logic [NUM_CH-1:0]       err_o,
  output logic [NUM_CH-1:0]       wrap_o
);
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    quad_ch #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .INV(DIR_INV[g])) u_ch (
      .clk       (clk_clk),
      .rst       (reset_reset),
      .a         (quad_a[g]),
      .b         (quad_b[g]),
      .cnt_clr   (cnt_clr[g]),
      .flag_clr  (flag_clr[g]),
      .snap_req  (snap_req),
      .count     (count_o[g*CNT_W +: CNT_W]),
      .snap_count(snap_count_o[g*CNT_W +: CNT_W]),
      .err       (err_o[g]),
      .wrap      (wrap_o[g])
    );
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) snap_valid <= 1'b0;
    else             snap_valid <= snap_req;
  end
endmodule
